// File: rtl/flex_rollover_counter_pkg.sv
// ----------------------------------------------------------------------------
// flex_counter_pkg
// Shared definitions for the flex_rollover_counter slice.
//   DEFAULT_CNT_BITS : default width of the count and of the rollover value
//   WRAP_CNT_BITS    : width of the optional saturating rollover tally
//   cnt_op_e         : decision taken at each clock edge, highest priority first
// ----------------------------------------------------------------------------
package flex_counter_pkg;

   localparam int DEFAULT_CNT_BITS = 4;
   localparam int WRAP_CNT_BITS    = 8;

   typedef enum logic [2:0] {
      CNT_RESET,
      CNT_CLEAR,
      CNT_INC,
      CNT_WRAP,
      CNT_HOLD
   } cnt_op_e;

endpackage

// File: rtl/flex_rollover_counter_if.sv
// ----------------------------------------------------------------------------
// flex_rollover_counter_if
// Control/status bundle of the rollover counter.
//   clear          : synchronous clear of count and flag (master -> slave)
//   count_enable   : advance the count this cycle       (master -> slave)
//   rollover_val   : terminal count value               (master -> slave)
//   count_out      : registered count                   (slave -> master)
//   rollover_flag  : registered count == rollover_val   (slave -> master)
//   wrap_count     : saturating rollover tally, only when
//                    FLEX_COUNTER_WRAP_CNT_EN is defined (slave -> master)
// ----------------------------------------------------------------------------
interface flex_rollover_counter_if
   import flex_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS = DEFAULT_CNT_BITS
);

   logic                    clear;
   logic                    count_enable;
   logic [NUM_CNT_BITS-1:0] rollover_val;
   logic [NUM_CNT_BITS-1:0] count_out;
   logic                    rollover_flag;
`ifdef FLEX_COUNTER_WRAP_CNT_EN
   logic [WRAP_CNT_BITS-1:0] wrap_count;

   modport master (
      output clear, count_enable, rollover_val,
      input  count_out, rollover_flag, wrap_count
   );

   modport slave (
      input  clear, count_enable, rollover_val,
      output count_out, rollover_flag, wrap_count
   );
`else
   modport master (
      output clear, count_enable, rollover_val,
      input  count_out, rollover_flag
   );

   modport slave (
      input  clear, count_enable, rollover_val,
      output count_out, rollover_flag
   );
`endif

endinterface

// File: rtl/flex_rollover_counter_next.sv
// ----------------------------------------------------------------------------
// flex_counter_next
// Purely combinational next-state logic of the rollover counter.
//   n_rst_i          : active-low reset request
//   clear_i          : clear request
//   count_enable_i   : advance request
//   rollover_val_i   : terminal count value
//   count_i, flag_i  : current registered count and flag
//   count_d_o        : next count
//   flag_d_o         : next flag (next count == rollover_val)
//   wrap_o           : strobe, an enabled edge that wraps the count back to 1
// ----------------------------------------------------------------------------
module flex_counter_next
   import flex_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS = DEFAULT_CNT_BITS
) (
   input  logic                    n_rst_i,
   input  logic                    clear_i,
   input  logic                    count_enable_i,
   input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
   input  logic [NUM_CNT_BITS-1:0] count_i,
   input  logic                    flag_i,
   output logic [NUM_CNT_BITS-1:0] count_d_o,
   output logic                    flag_d_o,
   output logic                    wrap_o
);

   localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

   cnt_op_e                 op;
   logic [NUM_CNT_BITS-1:0] cnt_inc;

   // Only reached when count_i < rollover_val_i, so this never overflows.
   assign cnt_inc = count_i + ONE;

   always_comb begin
      op = CNT_HOLD;
      if (!n_rst_i) begin
         op = CNT_RESET;
      end else if (clear_i) begin
         op = CNT_CLEAR;
      end else if (count_enable_i) begin
         // A zero terminal value disables the counter: it reads as cleared.
         if (rollover_val_i == '0)
            op = CNT_CLEAR;
         // >= rather than == so a lowered rollover_val still wraps.
         else if (count_i >= rollover_val_i)
            op = CNT_WRAP;
         else
            op = CNT_INC;
      end
   end

   always_comb begin
      count_d_o = count_i;
      flag_d_o  = flag_i;
      wrap_o    = 1'b0;
      unique case (op)
         CNT_RESET, CNT_CLEAR: begin
            count_d_o = '0;
            flag_d_o  = 1'b0;
         end
         CNT_WRAP: begin
            count_d_o = ONE;
            flag_d_o  = (rollover_val_i == ONE);
            wrap_o    = 1'b1;
         end
         CNT_INC: begin
            count_d_o = cnt_inc;
            flag_d_o  = (cnt_inc == rollover_val_i);
         end
         default: begin
            count_d_o = count_i;
            flag_d_o  = flag_i;
         end
      endcase
   end

endmodule

// File: rtl/flex_rollover_counter.sv
// ----------------------------------------------------------------------------
// flex_rollover_counter
// Up-counter with a run-time programmable rollover value. Counts 1..R and
// wraps to 1; rollover_flag is high while the count equals R. All outputs are
// registered.
//   clk    : system clock, rising edge
//   n_rst  : synchronous active-low reset
//   bus    : flex_rollover_counter_if.slave (clear, count_enable,
//            rollover_val in; count_out, rollover_flag [, wrap_count] out)
// Build option FLEX_COUNTER_WRAP_CNT_EN adds bus.wrap_count, a saturating
// 8-bit tally of rollovers, zeroed by reset or clear.
// ----------------------------------------------------------------------------
module flex_rollover_counter
   import flex_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS = DEFAULT_CNT_BITS
) (
   input  logic                    clk,
   input  logic                    n_rst,
   flex_rollover_counter_if.slave  bus
);

   logic [NUM_CNT_BITS-1:0] count_q, count_d;
   logic                    flag_q, flag_d;
   logic                    wrap_stb;

   flex_counter_next #(
      .NUM_CNT_BITS (NUM_CNT_BITS)
   ) u_next (
      .n_rst_i        (n_rst),
      .clear_i        (bus.clear),
      .count_enable_i (bus.count_enable),
      .rollover_val_i (bus.rollover_val),
      .count_i        (count_q),
      .flag_i         (flag_q),
      .count_d_o      (count_d),
      .flag_d_o       (flag_d),
      .wrap_o         (wrap_stb)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         flag_q  <= flag_d;
      end
   end

   assign bus.count_out     = count_q;
   assign bus.rollover_flag = flag_q;

`ifdef FLEX_COUNTER_WRAP_CNT_EN
   logic [WRAP_CNT_BITS-1:0] wrap_q;

   always_ff @(posedge clk) begin
      if (!n_rst || bus.clear)
         wrap_q <= '0;
      else if (wrap_stb && (wrap_q != '1))
         wrap_q <= wrap_q + WRAP_CNT_BITS'(1);
   end

   assign bus.wrap_count = wrap_q;
`else
   logic unused_wrap_stb;
   assign unused_wrap_stb = wrap_stb;
`endif

endmodule

// File: tb/tb_flex_rollover_counter.sv
module tb_flex_rollover_counter;

   localparam int W = 4;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   flex_rollover_counter_if #(.NUM_CNT_BITS(W)) bus ();

   flex_rollover_counter #(.NUM_CNT_BITS(W)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int m_cnt = 0;
   int m_flag = 0;
   int m_wrap = 0;
   bit chk_en = 1'b0;

   int exp_wrap_seq[10] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};

   task automatic check(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
      end
   endtask

   // Behavioural reference: what one rising edge must do given the inputs.
   task automatic model_step();
      int rv;
      rv = int'(bus.rollover_val);
      if (!n_rst || bus.clear) begin
         m_cnt = 0; m_flag = 0; m_wrap = 0;
      end else if (bus.count_enable) begin
         if (rv == 0) begin
            m_cnt = 0;
         end else if (m_cnt >= rv) begin
            m_cnt = 1;
            if (m_wrap < 255) m_wrap++;
         end else begin
            m_cnt = m_cnt + 1;
         end
         m_flag = (rv != 0 && m_cnt == rv) ? 1 : 0;
      end
   endtask

   // Model comparison on every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_count", int'(bus.count_out), m_cnt);
         check("model_flag", int'(bus.rollover_flag), m_flag);
`ifdef FLEX_COUNTER_WRAP_CNT_EN
         check("model_wrap", int'(bus.wrap_count), m_wrap);
`endif
      end
   end

   task automatic drive(input bit r, input bit c, input bit e, input int rv);
      n_rst            = r;
      bus.clear        = c;
      bus.count_enable = e;
      bus.rollover_val = W'(rv);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic lit(input string nm, input int cnt, input int flg);
      check({nm, "_count"}, int'(bus.count_out), cnt);
      check({nm, "_flag"}, int'(bus.rollover_flag), flg);
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b1, 15);
      cyc();
      chk_en = 1'b1;

      // Reset holds everything at zero even with enable high.
      for (int i = 0; i < 10; i++) begin
         cyc();
         lit("reset", 0, 0);
      end
      drive(1'b1, 1'b0, 1'b1, 15);
      cyc();
      lit("reset_release", 1, 0);

      // Normal wrap at 4.
      drive(1'b1, 1'b1, 1'b1, 4);
      cyc();
      lit("pre_clear", 0, 0);
      drive(1'b1, 1'b0, 1'b1, 4);
      for (int i = 0; i < 10; i++) begin
         cyc();
         lit("wrap4", exp_wrap_seq[i], (exp_wrap_seq[i] == 4) ? 1 : 0);
      end

      // Park at 4 with enable low, then resume.
      run(2);
      lit("reach4", 4, 1);
      drive(1'b1, 1'b0, 1'b0, 4);
      for (int i = 0; i < 3; i++) begin
         cyc();
         lit("hold", 4, 1);
      end
      drive(1'b1, 1'b0, 1'b1, 4);
      cyc();
      lit("resume", 1, 0);

      // Clear beats enable.
      drive(1'b1, 1'b1, 1'b1, 4);
      for (int i = 0; i < 3; i++) begin
         cyc();
         lit("clear_rv4", 0, 0);
      end
      drive(1'b1, 1'b1, 1'b1, 1);
      for (int i = 0; i < 2; i++) begin
         cyc();
         lit("clear_rv1", 0, 0);
      end
      drive(1'b1, 1'b0, 1'b1, 1);
      cyc();
      lit("rv1_first", 1, 1);
      cyc();
      lit("rv1_stay", 1, 1);

      // Lowering rollover_val under the current count.
      drive(1'b1, 1'b1, 1'b0, 15);
      cyc();
      drive(1'b1, 1'b0, 1'b1, 15);
      run(9);
      lit("up_to9", 9, 0);
      drive(1'b1, 1'b0, 1'b1, 10);
      cyc();
      lit("rv10_hit", 10, 1);
      cyc();
      lit("rv10_wrap", 1, 0);
      drive(1'b1, 1'b0, 1'b1, 15);
      run(8);
      lit("again9", 9, 0);
      drive(1'b1, 1'b0, 1'b1, 5);
      cyc();
      lit("rv5_below", 1, 0);

      // Full scale.
      drive(1'b1, 1'b0, 1'b1, 15);
      run(13);
      lit("at14", 14, 0);
      cyc();
      lit("full_hit", 15, 1);
      cyc();
      lit("full_wrap", 1, 0);

      // Zero rollover disables the counter.
      drive(1'b1, 1'b1, 1'b0, 0);
      cyc();
      drive(1'b1, 1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         lit("rv0", 0, 0);
      end

`ifdef FLEX_COUNTER_WRAP_CNT_EN
      // Every edge after the first wraps when rollover_val is 1.
      drive(1'b1, 1'b1, 1'b0, 1);
      cyc();
      drive(1'b1, 1'b0, 1'b1, 1);
      run(5);
      check("wrap_cnt_4", int'(bus.wrap_count), 4);
      run(295);
      check("wrap_cnt_sat", int'(bus.wrap_count), 255);
`endif

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int rv;
         rv = int'(bus.rollover_val);
         if ($urandom_range(7) == 0) rv = int'($urandom_range(15));
         drive(($urandom_range(63) != 0),
               ($urandom_range(15) == 0),
               ($urandom_range(3) != 0),
               rv);
         cyc();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
